// File: rtl/aemb2_pkg.sv
// Shared types and constants for the AEMB2 pipeline scheduler.
package aemb2_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        BAD  = 2'd3
    } state_t;

    localparam int   TOW_DEF = 8;
    localparam logic PHA_T0  = 1'b0;
    localparam logic PHA_T1  = 1'b1;

endpackage

// File: rtl/aemb2_tmo_cnt.sv
// Bus-timeout counter: tmo fires during the stall cycle that completes 2^TOW-1 stalls.
module aemb2_tmo_cnt #(
    parameter int TOW = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cnt_en,
    input  logic clr,
    output logic tmo
);

    localparam logic [TOW-1:0] CNT_ZERO = {TOW{1'b0}};
    localparam logic [TOW-1:0] CNT_ONE  = {{(TOW-1){1'b0}}, 1'b1};
    // Count already holds the stalls before this one, so 2^TOW-2 means this is the last.
    localparam logic [TOW-1:0] CNT_LAST = {{(TOW-1){1'b1}}, 1'b0};

    logic [TOW-1:0] r_cnt;

    // Stall-cycle counter, cleared whenever the pipeline advances
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= CNT_ZERO;
        end else if (clr) begin
            r_cnt <= CNT_ZERO;
        end else if (cnt_en) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign tmo = cnt_en & (r_cnt == CNT_LAST);

endmodule

// File: rtl/aemb2_pipe_sched.sv
// AEMB2 pipeline scheduler: BOOT/RUN/HALT FSM, thread phase and optional bus timeout.
// Optional feature: define AEMB2_BUS_TIMEOUT_EN to build the bus-timeout abort logic.
module aemb2_pipe_sched
    import aemb2_pkg::*;
#(
    parameter int TXE = 1,
    parameter int TOW = TOW_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       iwb_ack_i,
    input  logic       dwb_stb_i,
    input  logic       dwb_ack_i,
    input  logic       msr_txe_i,
    input  logic       hlt_i,
    output logic       iwb_stb_o,
    output logic       ena_o,
    output logic       pha_o,
    output logic       berr_o,
    output logic [1:0] state_o
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;
    logic   w_ack_ok;
    logic   w_tmo;
    logic   w_stb;
    logic   w_ena;
    logic   r_pha;

    assign w_run    = (r_state == RUN);
    assign w_ack_ok = iwb_ack_i & (~dwb_stb_i | dwb_ack_i);

`ifdef AEMB2_BUS_TIMEOUT_EN
    aemb2_tmo_cnt #(
        .TOW (TOW)
    ) u_tmo_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cnt_en (w_run & ~w_ack_ok),
        .clr    (w_ena),
        .tmo    (w_tmo)
    );
`else
    // No timeout hardware: RUN waits for acks indefinitely.
    assign w_tmo = (TOW < 0);
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe/enable decode
    always_comb begin
        w_state_nxt = BOOT;
        w_stb       = 1'b0;
        w_ena       = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_stb = 1'b1;
                w_ena = w_ack_ok | w_tmo;
                if (hlt_i && w_ena) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            HALT: begin
                if (hlt_i) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // Thread phase: toggles on each advance while thread extension is enabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pha <= PHA_T0;
        end else if (w_ena) begin
            if ((TXE != 0) && msr_txe_i) begin
                r_pha <= ~r_pha;
            end else begin
                r_pha <= PHA_T0;
            end
        end else begin
            r_pha <= r_pha;
        end
    end

    assign iwb_stb_o = w_stb;
    assign ena_o     = w_ena;
    assign pha_o     = r_pha;
    assign berr_o    = w_tmo;
    assign state_o   = r_state;

endmodule

// File: doc/aemb2_pipe_sched.md
AEMB2_PIPE_SCHED -- requirements
Module: aemb2_pipe_sched

Interface
REQ-001 Parameter TXE, default 1: thread-extension hardware present; when 0, pha_o is constant 0.
REQ-002 Parameter TOW, default 8: bus-timeout counter width in bits.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 iwb_ack_i  in  1  instruction-bus acknowledge.
REQ-006 dwb_stb_i  in  1  data-bus request outstanding from the MA stage.
REQ-007 dwb_ack_i  in  1  data-bus acknowledge.
REQ-008 msr_txe_i  in  1  MSR thread-extension enable.
REQ-009 hlt_i  in  1  external halt request, level-sensitive.
REQ-010 iwb_stb_o  out  1  instruction-fetch strobe.
REQ-011 ena_o  out  1  pipeline advance enable to all stages.
REQ-012 pha_o  out  1  thread phase selecting PC holding register 0 or 1.
REQ-013 berr_o  out  1  one-cycle bus-timeout pulse.
REQ-014 state_o  out  2  current FSM state, for debug.

Function
REQ-015 FSM states: BOOT=0, RUN=1, HALT=2; encoding 3 is unreachable and SHALL recover to BOOT on the next edge.
REQ-016 BOOT: iwb_stb_o=0, ena_o=0; next state RUN unconditionally, so BOOT lasts exactly 1 cycle.
REQ-017 RUN: iwb_stb_o=1.
REQ-018 RUN: ena_o = iwb_ack_i & (!dwb_stb_i | dwb_ack_i), combinational from the registered state, giving zero added latency.
REQ-019 HALT: iwb_stb_o=0, ena_o=0.
REQ-020 RUN->HALT on an edge where hlt_i=1 and ena_o=1, so no bus cycle is abandoned.
REQ-021 If hlt_i=1 with acks missing, the FSM stays in RUN until ena_o=1.
REQ-022 HALT->RUN on the first edge with hlt_i=0; fetch resumes the following cycle.
REQ-023 pha_o toggles on every edge with ena_o=1, only when TXE=1 and msr_txe_i=1.
REQ-024 If msr_txe_i=0 at an ena_o edge, pha_o is loaded with 0.
REQ-025 pha_o holds its value in HALT.
REQ-026 Simultaneous hlt_i=1 and ena_o=1: the pha_o toggle still occurs on that edge.
REQ-027 A dwb_ack_i arriving without dwb_stb_i is ignored.
REQ-028 An iwb_ack_i arriving outside RUN is ignored.

Reset
REQ-029 Asserting rst_i immediately forces: state=BOOT, pha_o=0, berr_o=0, timeout counter=0; ena_o=0 and iwb_stb_o=0 follow from state BOOT.
REQ-030 Reset mid-transaction discards the pending transaction; first fetch strobe is in the 2nd cycle after rst_i deasserts.

Configuration
REQ-031 Macro AEMB2_BUS_TIMEOUT_EN, when defined: a TOW-bit counter increments on each RUN cycle with ena_o=0 and clears on ena_o=1.
REQ-032 With AEMB2_BUS_TIMEOUT_EN defined, at count 2^TOW-1: berr_o=1 and ena_o forced to 1 for that cycle (abort-advance), and the counter clears.
REQ-033 With AEMB2_BUS_TIMEOUT_EN defined, hlt_i during an abort cycle is honoured per REQ-020.
REQ-034 Without the macro: no counter exists, berr_o is tied 0, and RUN waits for acks indefinitely.

Structure
REQ-035 Shared package aemb2_pkg holds: FSM state typedef/constants (BOOT, RUN, HALT), the default TOW value, and the phase constants PHA_T0=0 and PHA_T1=1.
REQ-036 Sub-module aemb2_tmo_cnt (parameter TOW; inputs clk_i, rst_i, cnt_en, clr; output tmo) implements the timeout counter.
REQ-037 aemb2_tmo_cnt is instantiated only under AEMB2_BUS_TIMEOUT_EN.
REQ-038 The FSM and phase logic stay in aemb2_pipe_sched.

Verification
REQ-039 Reset release, acks held 1, msr_txe_i=1 -> cycle 1 BOOT (ena_o=0); from cycle 2 ena_o=1 every cycle; pha_o sequence 0,1,0,1.
REQ-040 RUN, dwb_stb_i=1, dwb_ack_i delayed 3 cycles, iwb_ack_i=1 -> ena_o=0 for 3 cycles, 1 on the ack cycle; pha_o frozen meanwhile.
REQ-041 hlt_i=1 while iwb_ack_i=0 for 2 cycles -> remain RUN; on ack: ena_o=1, then HALT, iwb_stb_o=0; hlt_i=0 -> RUN next edge.
REQ-042 msr_txe_i=0 with pha_o=1 -> next ena_o edge pha_o=0 and stays 0; with TXE=0, pha_o=0 always.
REQ-043 Macro defined, TOW=4, iwb_ack_i stuck 0 -> berr_o pulses in the 15th stall cycle with ena_o=1 and repeats every 15 cycles; macro undefined -> berr_o never asserts.
REQ-044 rst_i asserted asynchronously mid-stall -> outputs go to reset values before the next clock edge; recovery per REQ-030.
